// File: rtl/laplace_stream.sv
// Streaming 3x3 cross Laplacian (4e-b-d-f-h) over a raster-scan image.
// Two line buffers plus a small tap window; one registered output stage.
module laplace_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W+2:0] m_raw,
  output logic              m_last,
  output logic              frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned RW = DATA_W + 3;

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              mode_q;

  logic [DATA_W-1:0] lb1 [IMG_W];  // row y-1
  logic [DATA_W-1:0] lb2 [IMG_W];  // row y-2
  logic [DATA_W-1:0] e_q, d_q, b_q, h_q;

  logic              accept, x_end, y_end, win;
  logic [DATA_W-1:0] f_rd, b_rd, pix;
  logic signed [RW-1:0] raw;
  logic [RW-1:0]     mag;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign x_end   = (x_q == XW'(IMG_W - 1));
  assign y_end   = (y_q == YW'(IMG_H - 1));
  assign win     = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));
  assign f_rd    = lb1[x_q];
  assign b_rd    = lb2[x_q];

  // Window for centre (y-1,x-1): f comes straight from the buffer, e/d are the
  // row y-1 taps, b is the delayed row y-2 read, h the previous current-row pixel.
  always_comb begin
    raw = RW'({e_q, 2'b00}) - RW'(b_q) - RW'(d_q) - RW'(f_rd) - RW'(h_q);
    mag = raw[RW-1] ? RW'(-raw) : RW'(raw);
    pix = '0;
    if (!mode_q) begin
      if (raw[RW-1])                pix = '0;
      else if (|raw[RW-2:DATA_W])   pix = '1;
      else                          pix = raw[DATA_W-1:0];
    end else begin
      if (|mag[RW-1:DATA_W])        pix = '1;
      else                          pix = mag[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_raw      <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && x_end && y_end;
      if (accept) begin
        if (x_q == '0 && y_q == '0) mode_q <= mode;
        if (x_end) begin
          x_q <= '0;
          y_q <= y_end ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      if (win) begin
        m_valid <= 1'b1;
        m_data  <= pix;
        m_raw   <= raw;
        m_last  <= x_end && y_end;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

  // Pixel storage is deliberately not reset; window gating keeps stale rows out.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[x_q] <= s_data;
      lb2[x_q] <= f_rd;
      e_q      <= f_rd;
      d_q      <= e_q;
      b_q      <= b_rd;
      h_q      <= s_data;
    end
  end

endmodule

// File: tb/tb_laplace_stream.sv
// Self-checking bench for laplace_stream: a 4x4 and a 5x5 instance driven by
// directed and random frames, checked against an image-level Laplacian model.
module tb_laplace_stream;

  typedef struct {
    int raw;
    int data;
    int last;
  } exp_t;

  logic       clk;
  logic       rst_n_a      [2];
  logic       mode_a       [2];
  logic       s_valid_a    [2];
  logic       s_ready_a    [2];
  logic [7:0] s_data_a     [2];
  logic       m_valid_a    [2];
  logic       m_ready_a    [2];
  logic [7:0] m_data_a     [2];
  logic [10:0] m_raw_a     [2];
  logic       m_last_a     [2];
  logic       frame_done_a [2];

  int   errors = 0;
  int   checks = 0;
  int   img [5][5];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t mon_e;
  int   n_out [2], n_last [2], n_done [2];
  int   exp_out [2], exp_last [2], exp_done [2];
  bit   stall_prev [2];
  logic [7:0]  prev_data [2];
  logic [10:0] prev_raw  [2];

  laplace_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n_a[0]), .mode(mode_a[0]),
    .s_valid(s_valid_a[0]), .s_ready(s_ready_a[0]), .s_data(s_data_a[0]),
    .m_valid(m_valid_a[0]), .m_ready(m_ready_a[0]), .m_data(m_data_a[0]),
    .m_raw(m_raw_a[0]), .m_last(m_last_a[0]), .frame_done(frame_done_a[0])
  );

  laplace_stream #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n_a[1]), .mode(mode_a[1]),
    .s_valid(s_valid_a[1]), .s_ready(s_ready_a[1]), .s_data(s_data_a[1]),
    .m_valid(m_valid_a[1]), .m_ready(m_ready_a[1]), .m_data(m_data_a[1]),
    .m_raw(m_raw_a[1]), .m_last(m_last_a[1]), .frame_done(frame_done_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int s);
    if (s == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference: Laplacian of every interior centre whose window completes
  // within the first npix pixels, in raster order of centres.
  function automatic void push_expected(input int s, input int w, input int h, input bit md,
                                        input int npix);
    exp_t e;
    for (int cy = 1; cy < h - 1; cy++) begin
      for (int cx = 1; cx < w - 1; cx++) begin
        if ((cy + 1) * w + cx + 1 < npix) begin
          e.raw = 4 * img[cy][cx] - img[cy-1][cx] - img[cy][cx-1] - img[cy][cx+1]
                  - img[cy+1][cx];
          if (!md) e.data = (e.raw < 0) ? 0 : (e.raw > 255) ? 255 : e.raw;
          else     e.data = ((e.raw < 0 ? -e.raw : e.raw) > 255) ? 255
                            : (e.raw < 0 ? -e.raw : e.raw);
          e.last = (cy == h - 2 && cx == w - 2) ? 1 : 0;
          if (s == 0) q0.push_back(e); else q1.push_back(e);
          exp_out[s]++;
          if (e.last != 0) exp_last[s]++;
        end
      end
    end
  endfunction

  task automatic fill_random(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y][x] = $urandom_range(0, 255);
  endtask

  task automatic send_frame(input int s, input int w, input int h, input bit md,
                            input int toggle_at, input int stall_at, input bit rnd,
                            input int npix);
    int x, y, cyc;
    bit acc;
    push_expected(s, w, h, md, npix);
    if (npix == w * h) exp_done[s]++;
    mode_a[s] = md;
    for (int idx = 0; idx < npix; idx++) begin
      x = idx % w;
      y = idx / w;
      if (idx == stall_at) begin
        s_valid_a[s] = 1'b1;
        s_data_a[s]  = 8'(img[y][x]);
        m_ready_a[s] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_s_ready", int'(s_ready_a[s]), 0);
          @(posedge clk); #1;
        end
      end
      acc = 1'b0;
      cyc = 0;
      while (!acc) begin
        s_valid_a[s] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data_a[s]  = 8'(img[y][x]);
        m_ready_a[s] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk);
        acc = s_valid_a[s] && s_ready_a[s];
        @(posedge clk); #1;
        cyc++;
        if (!acc && cyc > 100) begin
          $display("FAIL accept_timeout: inst %0d pixel %0d observed no accept required accept",
                   s, idx);
          $fatal(1, "input stalled");
        end
      end
      if (idx == toggle_at) mode_a[s] = !md;
    end
    s_valid_a[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    int cyc = 0;
    s_valid_a[s] = 1'b0;
    m_ready_a[s] = 1'b1;
    while (qsize(s) != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    chk("drain_pending", qsize(s), 0);
  endtask

  task automatic do_reset(input int s);
    rst_n_a[s] = 1'b0;
    #1;
    chk("rst_m_valid", int'(m_valid_a[s]), 0);
    chk("rst_m_data", int'(m_data_a[s]), 0);
    chk("rst_m_raw", int'(m_raw_a[s]), 0);
    chk("rst_m_last", int'(m_last_a[s]), 0);
    chk("rst_frame_done", int'(frame_done_a[s]), 0);
    chk("rst_s_ready", int'(s_ready_a[s]), 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n_a[s] = 1'b1;
  endtask

  // Output monitor: scoreboard pop on each transfer, hold check while stalled.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_n_a[g]) begin
        if (stall_prev[g] && m_valid_a[g]) begin
          chk("hold_m_data", int'(m_data_a[g]), int'(prev_data[g]));
          chk("hold_m_raw", int'(m_raw_a[g]), int'(prev_raw[g]));
        end
        if (m_valid_a[g] && m_ready_a[g]) begin
          n_out[g]++;
          if (m_last_a[g]) n_last[g]++;
          if (qsize(g) == 0) begin
            chk("spurious_output", n_out[g], exp_out[g]);
          end else begin
            mon_e = qpop(g);
            chk("m_raw", int'($signed(m_raw_a[g])), mon_e.raw);
            chk("m_data", int'(m_data_a[g]), mon_e.data);
            chk("m_last", int'(m_last_a[g]), mon_e.last);
          end
        end
        if (frame_done_a[g]) n_done[g]++;
        stall_prev[g] = m_valid_a[g] && !m_ready_a[g];
        prev_data[g]  = m_data_a[g];
        prev_raw[g]   = m_raw_a[g];
      end else begin
        stall_prev[g] = 1'b0;
      end
    end
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n_a[g] = 1'b1; mode_a[g] = 1'b0; s_valid_a[g] = 1'b0;
      s_data_a[g] = '0; m_ready_a[g] = 1'b1;
      n_out[g] = 0; n_last[g] = 0; n_done[g] = 0;
      exp_out[g] = 0; exp_last[g] = 0; exp_done[g] = 0; stall_prev[g] = 1'b0;
    end
    #2;
    do_reset(0);
    do_reset(1);
    @(posedge clk); #1;

    // Constant image: all outputs zero, last on the fourth.
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) img[y][x] = 100;
    send_frame(0, 4, 4, 1'b0, -1, -1, 1'b0, 16);
    drain(0);
    chk("const_outputs", n_out[0], 4);

    // Impulse at (2,2), clamped then absolute mode, back to back.
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) img[y][x] = 0;
    img[2][2] = 200;
    send_frame(1, 5, 5, 1'b0, -1, -1, 1'b0, 25);
    send_frame(1, 5, 5, 1'b1, -1, -1, 1'b0, 25);
    drain(1);

    // Backpressure: five-cycle output stall with input pending.
    fill_random(5, 5);
    send_frame(1, 5, 5, 1'b0, -1, 13, 1'b0, 25);
    drain(1);

    // Mode toggled mid-frame only takes effect from the next frame.
    fill_random(5, 5);
    send_frame(1, 5, 5, 1'b1, 6, -1, 1'b0, 25);
    fill_random(5, 5);
    send_frame(1, 5, 5, 1'b0, 6, -1, 1'b0, 25);
    drain(1);

    // Reset mid-frame with an output pending, then a clean frame.
    fill_random(4, 4);
    send_frame(0, 4, 4, 1'b0, -1, -1, 1'b0, 12);
    m_ready_a[0] = 1'b0;
    chk("pre_reset_valid", int'(m_valid_a[0]), 1);
    do_reset(0);
    void'(q0.pop_back());
    exp_out[0]--;
    chk("post_reset_pending", qsize(0), 0);
    @(posedge clk); #1;
    fill_random(4, 4);
    send_frame(0, 4, 4, 1'b1, -1, -1, 1'b0, 16);
    drain(0);

    // Random images, random modes, random valid/ready, back to back.
    for (int f = 0; f < 30; f++) begin
      fill_random(5, 5);
      send_frame(1, 5, 5, 1'($urandom_range(0, 1)), -1, -1, 1'b1, 25);
    end
    drain(1);
    for (int f = 0; f < 10; f++) begin
      fill_random(4, 4);
      send_frame(0, 4, 4, 1'($urandom_range(0, 1)), -1, -1, 1'b1, 16);
    end
    drain(0);

    for (int g = 0; g < 2; g++) begin
      chk("output_count", n_out[g], exp_out[g]);
      chk("m_last_count", n_last[g], exp_last[g]);
      chk("frame_done_count", n_done[g], exp_done[g]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/laplace_stream.md
LAPLACE_STREAM -- requirements
Module: laplace_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 512, pixels per row (>=3).
REQ-003 The block SHALL have parameter IMG_H, default 512, rows per frame (>=3).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = clamped Laplacian, 1 = absolute-value Laplacian.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  block accepts the input pixel.
- s_data  input  DATA_W  input pixel, row-major order, unsigned.
- m_valid  output  1  output pixel valid.
- m_ready  input  1  downstream accepts the output pixel.
- m_data  output  DATA_W  filtered pixel.
- m_raw  output  DATA_W+3  signed unsaturated Laplacian.
- m_last  output  1  marks the last output of a frame.
- frame_done  output  1  one-cycle pulse when the last input pixel of a frame is accepted.

Function
REQ-005 An input transfer SHALL occur on a clock edge where s_valid and s_ready are both 1; an output transfer SHALL occur where m_valid and m_ready are both 1.
REQ-006 s_ready SHALL equal (!m_valid || m_ready), giving a single-stage output register with no combinational path from s_valid to m_valid.
REQ-007 Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) SHALL advance per input transfer; x wraps to 0 and y increments at x=IMG_W-1; both wrap to 0 after (IMG_W-1, IMG_H-1).
REQ-008 Two line buffers of depth IMG_W SHALL hold rows y-1 and y-2; the block SHALL also keep a 3-tap register on row y-1 and a 1-pixel register on the current row.
REQ-009 On accepting pixel (y,x) with y>=2 and x>=2, the block SHALL compute the result for centre (y-1,x-1) using b=(y-2,x-1), d=(y-1,x-2), e=(y-1,x-1), f=(y-1,x), h=(y,x-1).
REQ-010 No output SHALL be produced for border pixels; each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) outputs, in row-major order of the centres.
REQ-011 m_raw SHALL equal 4e-b-d-f-h, computed in signed DATA_W+3 bits without overflow.
REQ-012 With mode=0, m_data SHALL be m_raw clamped to [0, 2^DATA_W-1].
REQ-013 With mode=1, m_data SHALL be |m_raw| saturated to 2^DATA_W-1.
REQ-014 mode SHALL be sampled on acceptance of pixel (0,0) and held for the whole frame; changes to mode mid-frame SHALL have no effect until the next frame.
REQ-015 m_valid SHALL assert on the edge following the input transfer that completes a window (latency 1 cycle); m_data, m_raw and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-016 m_last SHALL be 1 only with the output for centre (IMG_H-2, IMG_W-2).
REQ-017 frame_done SHALL pulse for exactly one cycle on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-018 Back-to-back frames SHALL be accepted with no idle cycles, and no data from a previous frame SHALL appear in any window of the next frame.

Reset
REQ-019 When rst_n=0, x, y, m_valid, m_last and frame_done SHALL be 0 immediately, m_data and m_raw SHALL be 0, and the sampled mode SHALL be 0.
REQ-020 Line-buffer contents SHALL NOT be reset; a reset mid-frame SHALL discard the partial frame, and the next accepted pixel SHALL be treated as (0,0).

Verification
REQ-021 Constant image: IMG_W=IMG_H=4, all pixels 100, mode=0 -> exactly 4 outputs, m_data=0, m_raw=0, m_last on the 4th output.
REQ-022 Impulse: IMG_W=IMG_H=5, pixel (2,2)=200 and all others 0 -> centre output m_raw=800, m_data=255; the four neighbours give m_raw=-200, with m_data=0 when mode=0 and m_data=200 when mode=1.
REQ-023 Backpressure: hold m_ready=0 for 5 cycles while s_valid=1 -> s_ready=0 and m_data unchanged during the stall; no pixel is lost or duplicated against the reference model.
REQ-024 Mode latch: toggle mode mid-frame -> all outputs of that frame use the mode sampled at pixel (0,0); the next frame uses the new mode.
REQ-025 Reset mid-frame: assert rst_n=0 after row 2, then send a full 4x4 frame -> exactly 4 correct outputs, none of them computed from pre-reset data.
REQ-026 Full frame: 512x512 random image with random s_valid/m_ready -> 260100 outputs bit-exact to the model, a single m_last, and a single frame_done.
